// File: rtl/bg_frame_controller.sv
// bg_frame_controller
//   Sequences one frame across NUM_PE background-removal PEs.
//   Phase 1 starts the per-PE channel sums, captures them and acks the PEs.
//   It then averages each channel over the frame, saturating to 8 bits.
//   Phase 2 starts background removal, acks it and pulses Done.
//
//   Optional macro BG_CTRL_WATCHDOG_EN adds a per-wait-state watchdog
//   (TIMEOUT cycles). On expiry it sets a sticky Error, pulses Ack and
//   returns to IDLE.
//
// Ports:
//   Clk, Reset         clock (rising edge), synchronous active-high reset
//   Go                 frame start request, sampled only in IDLE
//   Start_Sum          one-cycle pulse: PEs begin channel summation
//   Start_BgRemoval    one-cycle pulse: PEs begin background removal
//   Ack                one-cycle pulse closing each phase
//   Qsd, Qbgd          per-PE sum-done / bg-done flags
//   red/green/blue_sum packed per-PE sums, PE k at [k*SUM_W +: SUM_W]
//   red/green/blue_exp frame-average expected colour
//   Busy               high outside IDLE
//   Done               one-cycle frame-complete pulse
//   Error              watchdog expiry (constant 0 without the macro)
module bg_frame_controller #(
  parameter int NUM_PE         = 4,
  parameter int SUM_W          = 16,
  parameter int LOG2_TOTAL_PIX = 3,
  parameter int TIMEOUT        = 1023
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Go,
  output logic                    Start_Sum,
  output logic                    Start_BgRemoval,
  output logic                    Ack,
  input  logic [NUM_PE-1:0]       Qsd,
  input  logic [NUM_PE-1:0]       Qbgd,
  input  logic [SUM_W*NUM_PE-1:0] red_sum,
  input  logic [SUM_W*NUM_PE-1:0] green_sum,
  input  logic [SUM_W*NUM_PE-1:0] blue_sum,
  output logic [7:0]              red_exp,
  output logic [7:0]              green_exp,
  output logic [7:0]              blue_exp,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);

  localparam int ACC_W = SUM_W + 4;
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  if (NUM_PE < 1 || NUM_PE > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("bg_frame_controller: NUM_PE must be 1..16 and TIMEOUT >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_SUM_START, S_SUM_WAIT, S_SUM_ACK, S_SUM_RELEASE, S_ACCUM,
    S_AVERAGE, S_BG_START, S_BG_WAIT, S_BG_ACK, S_BG_RELEASE, S_DONE
  } state_t;

  state_t                  state;
  logic [SUM_W*NUM_PE-1:0] cap_r, cap_g, cap_b;
  logic [ACC_W-1:0]        acc_r, acc_g, acc_b;
  logic [IDX_W-1:0]        idx;

  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] v);
    return (v > ACC_W'(255)) ? 8'hFF : v[7:0];
  endfunction

`ifdef BG_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;
  logic            wd_expire;

  // Wait/release states are never adjacent, so clearing the counter whenever
  // the FSM is outside them restarts it on entry to each one.
  assign in_wait   = (state == S_SUM_WAIT) || (state == S_SUM_RELEASE) ||
                     (state == S_BG_WAIT)  || (state == S_BG_RELEASE);
  assign wd_expire = in_wait && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
  assign Error = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= S_IDLE;
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      red_exp         <= '0;
      green_exp       <= '0;
      blue_exp        <= '0;
      cap_r           <= '0;
      cap_g           <= '0;
      cap_b           <= '0;
      acc_r           <= '0;
      acc_g           <= '0;
      acc_b           <= '0;
      idx             <= '0;
`ifdef BG_CTRL_WATCHDOG_EN
      Error           <= 1'b0;
      wd_cnt          <= '0;
`endif
    end else begin
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Done            <= 1'b0;
`ifdef BG_CTRL_WATCHDOG_EN
      wd_cnt          <= in_wait ? wd_cnt + 1'b1 : '0;
`endif
      case (state)
        S_IDLE: if (Go) begin
          state     <= S_SUM_START;
          Start_Sum <= 1'b1;
          Busy      <= 1'b1;
`ifdef BG_CTRL_WATCHDOG_EN
          Error     <= 1'b0;
`endif
        end
        S_SUM_START: state <= S_SUM_WAIT;
        S_SUM_WAIT: if (&Qsd) begin
          // Sums are only valid until the PEs see Ack, so latch them now.
          cap_r <= red_sum;
          cap_g <= green_sum;
          cap_b <= blue_sum;
          Ack   <= 1'b1;
          state <= S_SUM_ACK;
        end
        S_SUM_ACK: state <= S_SUM_RELEASE;
        S_SUM_RELEASE: if (!(|Qsd)) begin
          acc_r <= '0;
          acc_g <= '0;
          acc_b <= '0;
          idx   <= '0;
          state <= S_ACCUM;
        end
        S_ACCUM: begin
          acc_r <= acc_r + ACC_W'(cap_r[idx*SUM_W +: SUM_W]);
          acc_g <= acc_g + ACC_W'(cap_g[idx*SUM_W +: SUM_W]);
          acc_b <= acc_b + ACC_W'(cap_b[idx*SUM_W +: SUM_W]);
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(NUM_PE - 1)) state <= S_AVERAGE;
        end
        S_AVERAGE: begin
          red_exp         <= sat8(acc_r >> LOG2_TOTAL_PIX);
          green_exp       <= sat8(acc_g >> LOG2_TOTAL_PIX);
          blue_exp        <= sat8(acc_b >> LOG2_TOTAL_PIX);
          Start_BgRemoval <= 1'b1;
          state           <= S_BG_START;
        end
        S_BG_START: state <= S_BG_WAIT;
        S_BG_WAIT: if (&Qbgd) begin
          Ack   <= 1'b1;
          state <= S_BG_ACK;
        end
        S_BG_ACK: state <= S_BG_RELEASE;
        S_BG_RELEASE: if (!(|Qbgd)) begin
          Done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
`ifdef BG_CTRL_WATCHDOG_EN
      // Expiry overrides whatever the wait state decided this cycle.
      if (wd_expire) begin
        Error <= 1'b1;
        Ack   <= 1'b1;
        Busy  <= 1'b0;
        state <= S_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bg_frame_controller.sv
module tb_bg_frame_controller;
  localparam int NPE  = 4;
  localparam int SW   = 16;
  localparam int L2P  = 3;
  localparam int TOUT = 20;

  logic            Clk, Reset, Go;
  logic            Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
  logic [NPE-1:0]  Qsd, Qbgd;
  logic [SW*NPE-1:0] red_sum, green_sum, blue_sum;
  logic [7:0]      red_exp, green_exp, blue_exp;

  int n_chk = 0;
  int n_fail = 0;
  int ack_cnt = 0, done_cnt = 0, ss_cnt = 0, overlap_cnt = 0;
  int rs[NPE], gs[NPE], bs[NPE], qd[NPE];

  bg_frame_controller #(.NUM_PE(NPE), .SUM_W(SW), .LOG2_TOTAL_PIX(L2P), .TIMEOUT(TOUT)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .Qsd(Qsd), .Qbgd(Qbgd),
    .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Ack === 1'b1) ack_cnt++;
    if (Done === 1'b1) done_cnt++;
    if (Start_Sum === 1'b1) ss_cnt++;
    if (((Start_Sum === 1'b1) + (Start_BgRemoval === 1'b1) + (Ack === 1'b1)) > 1) overlap_cnt++;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Reference: average of all PE sums over 2^L2P pixels, clipped to 255.
  function automatic int model_exp(input int v[NPE]);
    int t = 0;
    foreach (v[k]) t += v[k];
    t = t / (1 << L2P);
    return (t > 255) ? 255 : t;
  endfunction

  task automatic drive_bus(input bit junk);
    for (int k = 0; k < NPE; k++) begin
      red_sum[k*SW +: SW]   = junk ? SW'($urandom) : SW'(rs[k]);
      green_sum[k*SW +: SW] = junk ? SW'($urandom) : SW'(gs[k]);
      blue_sum[k*SW +: SW]  = junk ? SW'($urandom) : SW'(bs[k]);
    end
  endtask

  // One full frame. Buses carry junk except in the cycle the last Qsd rises.
  task automatic run_frame(input string nm, input int bgd, input bit go_in_bg);
    int maxd, c, ack0, done0, ss0, er, eg, eb;
    bit early;
    ack0 = ack_cnt; done0 = done_cnt; ss0 = ss_cnt;
    er = model_exp(rs); eg = model_exp(gs); eb = model_exp(bs);
    maxd = 1;
    for (int k = 0; k < NPE; k++) if (qd[k] > maxd) maxd = qd[k];
    drive_bus(1'b1);
    Go = 1'b1; tick; Go = 1'b0;
    n_chk++; if (Start_Sum !== 1'b1) begin n_fail++; $display("FAIL %s start_latency: Start_Sum=%b want 1", nm, Start_Sum); end
    n_chk++; if (Error !== 1'b0) begin n_fail++; $display("FAIL %s error_clear: Error=%b want 0", nm, Error); end
    early = 1'b0;
    for (c = 1; c <= maxd; c++) begin
      tick;
      if (Ack !== 1'b0) early = 1'b1;
      for (int k = 0; k < NPE; k++) if (qd[k] == c) Qsd[k] = 1'b1;
      drive_bus(c != maxd);
    end
    n_chk++; if (early) begin n_fail++; $display("FAIL %s early_ack: Ack seen before all Qsd high, want none", nm); end
    tick; drive_bus(1'b1);
    n_chk++; if (Ack !== 1'b1) begin n_fail++; $display("FAIL %s sum_ack: Ack=%b want 1", nm, Ack); end
    Qsd = '0;
    for (c = 0; c < 40 && Start_BgRemoval !== 1'b1; c++) tick;
    n_chk++; if (Start_BgRemoval !== 1'b1) begin n_fail++; $display("FAIL %s bg_start: timeout, Start_BgRemoval=%b want 1", nm, Start_BgRemoval); end
    n_chk++; if (red_exp !== 8'(er)) begin n_fail++; $display("FAIL %s red_exp: got %0d want %0d", nm, red_exp, er); end
    n_chk++; if (green_exp !== 8'(eg)) begin n_fail++; $display("FAIL %s green_exp: got %0d want %0d", nm, green_exp, eg); end
    n_chk++; if (blue_exp !== 8'(eb)) begin n_fail++; $display("FAIL %s blue_exp: got %0d want %0d", nm, blue_exp, eb); end
    n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_mid: Busy=%b want 1", nm, Busy); end
    for (c = 1; c <= bgd; c++) begin
      tick;
      Go = go_in_bg && (c == 2);
    end
    Go = 1'b0;
    Qbgd = '1;
    for (c = 0; c < 40 && Ack !== 1'b1; c++) tick;
    Qbgd = '0;
    for (c = 0; c < 40 && Done !== 1'b1; c++) tick;
    n_chk++; if (Done !== 1'b1) begin n_fail++; $display("FAIL %s done: timeout, Done=%b want 1", nm, Done); end
    tick;
    n_chk++; if (ack_cnt - ack0 != 2) begin n_fail++; $display("FAIL %s ack_count: got %0d want 2", nm, ack_cnt - ack0); end
    n_chk++; if (done_cnt - done0 != 1) begin n_fail++; $display("FAIL %s done_count: got %0d want 1", nm, done_cnt - done0); end
    n_chk++; if (ss_cnt - ss0 != 1) begin n_fail++; $display("FAIL %s start_count: got %0d want 1", nm, ss_cnt - ss0); end
    n_chk++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_idle: Busy=%b want 0", nm, Busy); end
  endtask

  task automatic check_idle_outputs(input string nm);
    n_chk++;
    if ({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error} !== 6'b0 ||
        {red_exp, green_exp, blue_exp} !== 24'h0) begin
      n_fail++;
      $display("FAIL %s: ss=%b sb=%b ack=%b busy=%b done=%b err=%b exp=%0d/%0d/%0d want all 0",
               nm, Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error, red_exp, green_exp, blue_exp);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; tick; tick;
    check_idle_outputs("reset_state");
    Reset = 1'b0; tick;
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_basic;
    rs = '{100, 200, 300, 400}; gs = '{8, 8, 8, 8}; bs = '{0, 0, 0, 0};
    qd = '{5, 5, 5, 5};
    run_frame("basic", 3, 1'b0);
  endtask

  task automatic test_skew;
    rs = '{11, 22, 33, 44}; gs = '{500, 60, 7, 1}; bs = '{80, 80, 80, 80};
    qd = '{2, 7, 3, 9};
    run_frame("skew", 2, 1'b0);
  endtask

  task automatic test_saturation;
    rs = '{4000, 4000, 4000, 4000}; gs = '{2040, 0, 0, 0}; bs = '{65535, 65535, 65535, 65535};
    qd = '{1, 1, 1, 1};
    run_frame("saturation", 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    rs = '{1, 2, 3, 4}; gs = '{9, 9, 9, 9}; bs = '{16, 16, 16, 16};
    qd = '{3, 1, 2, 4};
    run_frame("go_in_bg_wait", 5, 1'b1);
    rs = '{800, 0, 0, 0}; qd = '{1, 2, 1, 2};
    run_frame("back_to_back", 1, 1'b0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < NPE; k++) begin
        rs[k] = $urandom_range(0, (f % 2) ? 65535 : 600);
        gs[k] = $urandom_range(0, 600);
        bs[k] = $urandom_range(0, (f % 3 == 0) ? 65535 : 300);
        qd[k] = $urandom_range(1, 8);
      end
      run_frame($sformatf("random%0d", f), $urandom_range(1, 6), 1'b0);
    end
  endtask

  task automatic test_reset_in_accum;
    int c;
    Go = 1'b1; tick; Go = 1'b0;
    tick; Qsd = '1; drive_bus(1'b1);
    for (c = 0; c < 10 && Ack !== 1'b1; c++) tick;
    Qsd = '0;
    tick; tick;  // SUM_RELEASE, then first ACCUM cycle
    n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL accum_busy: Busy=%b want 1", Busy); end
    Reset = 1'b1; tick;
    check_idle_outputs("reset_in_accum");
    Reset = 1'b0; tick; tick;
    n_chk++; if (Start_Sum !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL accum_abort_stays_idle: ss=%b busy=%b want 0 0", Start_Sum, Busy); end
  endtask

`ifdef BG_CTRL_WATCHDOG_EN
  task automatic test_watchdog;
    int c, ack0, done0;
    ack0 = ack_cnt; done0 = done_cnt;
    Go = 1'b1; tick; Go = 1'b0;
    tick; Qsd = '1;
    for (c = 0; c < 10 && Ack !== 1'b1; c++) tick;
    Qsd = '0;
    for (c = 0; c < 40 && Start_BgRemoval !== 1'b1; c++) tick;
    for (c = 0; c < TOUT; c++) tick;
    n_chk++; if (Error !== 1'b0) begin n_fail++; $display("FAIL wd_not_early: Error=%b want 0", Error); end
    tick;
    n_chk++; if (Error !== 1'b1 || Ack !== 1'b1 || Busy !== 1'b0) begin n_fail++; $display("FAIL wd_expire: err=%b ack=%b busy=%b want 1 1 0", Error, Ack, Busy); end
    tick; tick; tick;
    n_chk++; if (Error !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: Error=%b want 1", Error); end
    n_chk++; if (done_cnt != done0 || ack_cnt - ack0 != 2) begin n_fail++; $display("FAIL wd_pulses: done=%0d ack=%0d want 0 2", done_cnt - done0, ack_cnt - ack0); end
    rs = '{10, 20, 30, 40}; gs = '{0, 0, 0, 0}; bs = '{1, 1, 1, 1}; qd = '{1, 2, 3, 4};
    run_frame("after_watchdog", 2, 1'b0);
  endtask
`endif

  initial begin
    Reset = 1'b1; Go = 1'b0; Qsd = '0; Qbgd = '0;
    red_sum = '0; green_sum = '0; blue_sum = '0;
    test_reset;
    test_basic;
    test_skew;
    test_saturation;
    test_back_to_back;
    test_random;
    test_reset_in_accum;
`ifdef BG_CTRL_WATCHDOG_EN
    test_watchdog;
`endif
    n_chk++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL pulse_overlap: %0d cycles with overlapping pulses, want 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
